// File: rtl/fpu_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mult_pipe
// Brief    : Three-stage pipelined IEEE-754 multiplier with valid/ready stream,
//            special-value handling and FPU_MULT_RNE_EN-selected rounding
//            (round-to-nearest-even when defined, truncation otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module fpu_mult_pipe #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_overflow,
    output logic                   out_underflow,
    output logic                   out_invalid
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FPU_MULT_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    // Stage registers
    logic             s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
    logic             s1_spec_q, s1_spec_d, s1_inv_q, s1_inv_d;
    logic [W-1:0]     s1_sres_q, s1_sres_d;
    logic [XW-1:0]    s1_exp_q, s1_exp_d;
    logic [MAN_W:0]   s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    logic             s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
    logic             s2_spec_q, s2_spec_d, s2_inv_q, s2_inv_d;
    logic [W-1:0]     s2_sres_q, s2_sres_d;
    logic [XW-1:0]    s2_exp_q, s2_exp_d;
    logic [PW-1:0]    s2_prod_q, s2_prod_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_result_q, out_result_d;
    logic             out_ovf_q, out_ovf_d, out_unf_q, out_unf_d, out_inv_q, out_inv_d;

    logic             w_adv;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic             w_sign, w_invalid, w_special;
    logic [W-1:0]     w_sres;
    logic [PW-1:0]    w_prod;
    logic             w_msb, w_guard, w_sticky, w_inc, w_carry;
    logic [MAN_W-1:0] w_frac, w_frac_rnd;
    logic [XW-1:0]    w_exp_fin;
    logic             w_ovf, w_unf;
    logic [W-1:0]     w_result;

    assign w_adv      = !(out_valid_q && !out_ready);
    assign in_ready   = w_adv;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_overflow  = out_ovf_q;
    assign out_underflow = out_unf_q;
    assign out_invalid   = out_inv_q;

    // S1 decode: exp==0 covers both true zero and flushed subnormals
    assign w_ea = in_a[W-2:MAN_W];
    assign w_eb = in_b[W-2:MAN_W];
    assign w_fa = in_a[MAN_W-1:0];
    assign w_fb = in_b[MAN_W-1:0];

    always_comb begin
        w_zero_a  = (w_ea == '0);
        w_zero_b  = (w_eb == '0);
        w_nan_a   = (&w_ea) && (|w_fa);
        w_nan_b   = (&w_eb) && (|w_fb);
        w_inf_a   = (&w_ea) && !(|w_fa);
        w_inf_b   = (&w_eb) && !(|w_fb);
        w_sign    = in_a[W-1] ^ in_b[W-1];
        w_invalid = w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b);
        w_special = w_invalid || w_inf_a || w_inf_b || w_zero_a || w_zero_b;
        if (w_invalid)
            w_sres = QNAN;
        else if (w_inf_a || w_inf_b)
            w_sres = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            w_sres = {w_sign, {(W-1){1'b0}}};
    end

    // S2 mantissa product
    assign w_prod = {{(MAN_W+1){1'b0}}, s1_ma_q} * {{(MAN_W+1){1'b0}}, s1_mb_q};

    // S3 normalise by one position if the product reached [2,4)
    always_comb begin
        w_msb    = s2_prod_q[PW-1];
        w_frac   = w_msb ? s2_prod_q[2*MAN_W -: MAN_W] : s2_prod_q[2*MAN_W-1 -: MAN_W];
        w_guard  = w_msb ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
        w_sticky = w_msb ? (|s2_prod_q[MAN_W-1:0]) : (|s2_prod_q[MAN_W-2:0]);
        w_inc    = RNE & w_guard & (w_sticky | w_frac[0]);
        {w_carry, w_frac_rnd} = {1'b0, w_frac} + (MAN_W+1)'(w_inc);
        w_exp_fin = s2_exp_q + XW'(w_msb) + XW'(w_carry);
        w_ovf    = !w_exp_fin[XW-1] && (w_exp_fin >= EMAX_X);
        w_unf    = w_exp_fin[XW-1] || (w_exp_fin == '0);
        if (s2_spec_q)
            w_result = s2_sres_q;
        else if (w_ovf)
            w_result = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_unf)
            w_result = {s2_sign_q, {(W-1){1'b0}}};
        else
            w_result = {s2_sign_q, w_exp_fin[EXP_W-1:0], w_frac_rnd};
    end

    always_comb begin
        s1_valid_d = s1_valid_q;  s1_sign_d = s1_sign_q;  s1_spec_d = s1_spec_q;
        s1_inv_d   = s1_inv_q;    s1_sres_d = s1_sres_q;  s1_exp_d  = s1_exp_q;
        s1_ma_d    = s1_ma_q;     s1_mb_d   = s1_mb_q;
        s2_valid_d = s2_valid_q;  s2_sign_d = s2_sign_q;  s2_spec_d = s2_spec_q;
        s2_inv_d   = s2_inv_q;    s2_sres_d = s2_sres_q;  s2_exp_d  = s2_exp_q;
        s2_prod_d  = s2_prod_q;
        out_valid_d  = out_valid_q;  out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;    out_unf_d    = out_unf_q;   out_inv_d = out_inv_q;
        if (w_adv) begin
            s1_valid_d = in_valid;
            s1_sign_d  = w_sign;
            s1_spec_d  = w_special;
            s1_inv_d   = w_invalid;
            s1_sres_d  = w_sres;
            s1_exp_d   = XW'(w_ea) + XW'(w_eb) - BIAS_X;
            s1_ma_d    = {1'b1, w_fa};
            s1_mb_d    = {1'b1, w_fb};
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_spec_d  = s1_spec_q;
            s2_inv_d   = s1_inv_q;
            s2_sres_d  = s1_sres_q;
            s2_exp_d   = s1_exp_q;
            s2_prod_d  = w_prod;
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_result_d = w_result;
                out_inv_d    = s2_spec_q && s2_inv_q;
                out_ovf_d    = !s2_spec_q && w_ovf;
                out_unf_d    = !s2_spec_q && !w_ovf && w_unf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;  s1_sign_q <= 1'b0;  s1_spec_q <= 1'b0;  s1_inv_q <= 1'b0;
            s1_sres_q  <= '0;    s1_exp_q  <= '0;    s1_ma_q   <= '0;    s1_mb_q  <= '0;
            s2_valid_q <= 1'b0;  s2_sign_q <= 1'b0;  s2_spec_q <= 1'b0;  s2_inv_q <= 1'b0;
            s2_sres_q  <= '0;    s2_exp_q  <= '0;    s2_prod_q <= '0;
            out_valid_q  <= 1'b0;  out_result_q <= '0;
            out_ovf_q    <= 1'b0;  out_unf_q    <= 1'b0;  out_inv_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;  s1_sign_q <= s1_sign_d;  s1_spec_q <= s1_spec_d;
            s1_inv_q   <= s1_inv_d;    s1_sres_q <= s1_sres_d;  s1_exp_q  <= s1_exp_d;
            s1_ma_q    <= s1_ma_d;     s1_mb_q   <= s1_mb_d;
            s2_valid_q <= s2_valid_d;  s2_sign_q <= s2_sign_d;  s2_spec_q <= s2_spec_d;
            s2_inv_q   <= s2_inv_d;    s2_sres_q <= s2_sres_d;  s2_exp_q  <= s2_exp_d;
            s2_prod_q  <= s2_prod_d;
            out_valid_q  <= out_valid_d;  out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;    out_unf_q    <= out_unf_d;   out_inv_q <= out_inv_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_mult_pipe
// Brief    : Self-checking bench for fpu_mult_pipe (double precision), with a
//            queue-based reference model; honours FPU_MULT_RNE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_mult_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_invalid;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    logic [66:0] exp_q[$];

    fpu_mult_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_invalid   (out_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {invalid, overflow, underflow, result}
    function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b);
        logic s;
        int ea, eb, e, sh;
        logic [51:0] fa, fb;
        logic [127:0] p, frac;
`ifdef FPU_MULT_RNE_EN
        logic [127:0] rem, half;
`endif
        s  = a[63] ^ b[63];
        ea = int'(a[62:52]);
        eb = int'(b[62:52]);
        fa = a[51:0];
        fb = b[51:0];
        if ((ea == 2047 && fa != 0) || (eb == 2047 && fb != 0) ||
            (ea == 2047 && eb == 0) || (ea == 0 && eb == 2047))
            return {3'b100, 64'h7FF8_0000_0000_0000};
        if (ea == 2047 || eb == 2047)
            return {3'b000, s, 11'h7FF, 52'h0};
        if (ea == 0 || eb == 0)
            return {3'b000, s, 63'h0};
        p  = {75'h0, 1'b1, fa} * {75'h0, 1'b1, fb};
        sh = p[105] ? 53 : 52;
        e  = ea + eb - 1023 + (p[105] ? 1 : 0);
        frac = p >> sh;
`ifdef FPU_MULT_RNE_EN
        rem  = p - (frac << sh);
        half = 128'h1 << (sh - 1);
        if (rem > half || (rem == half && frac[0]))
            frac = frac + 1;
`endif
        if (frac[53]) begin
            frac = frac >> 1;
            e = e + 1;
        end
        if (e >= 2047)
            return {3'b010, s, 11'h7FF, 52'h0};
        if (e <= 0)
            return {3'b001, s, 63'h0};
        return {3'b000, s, e[10:0], frac[51:0]};
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] r;
        logic [10:0] ex;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 11))
            0: ex = 11'h000;
            1: begin ex = 11'h7FF; r[51:0] = '0; end
            2: begin ex = 11'h7FF; r[0] = 1'b1; end
            3: ex = r[62:52];
            4: ex = 11'(1 + $urandom_range(0, 3));
            5: ex = 11'(2046 - $urandom_range(0, 3));
            6: ex = 11'(510 + $urandom_range(0, 3));
            7: ex = 11'(1534 + $urandom_range(0, 3));
            8: begin ex = 11'(1020 + $urandom_range(0, 6)); r[51:0] = '1; end
            default: ex = 11'(1003 + $urandom_range(0, 40));
        endcase
        r[62:52] = ex;
        return r;
    endfunction

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: FIFO order against the model and stability under stall
    logic        hold_pending = 1'b0;
    logic [66:0] held_out;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending)
                check("stall_hold", {out_valid, out_invalid, out_overflow, out_underflow, out_result},
                      {1'b1, held_out[66:0]});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 67'(out_valid), 67'(0));
                end else begin
                    check("result", {out_invalid, out_overflow, out_underflow, out_result}, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            hold_pending = out_valid && !out_ready;
            held_out = {out_invalid, out_overflow, out_underflow, out_result};
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b));
        end
    end

    // Pair presented with an empty pipe must appear exactly three edges later
    task automatic directed(input string name, input logic [63:0] a, input logic [63:0] b,
                            input logic [66:0] lit);
        check({name, "_model"}, model(a, b), lit);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check({name, "_early"}, 67'(out_valid), 67'(0));
        @(posedge clk); #1;
        check({name, "_dut"}, {out_valid, out_invalid, out_overflow, out_underflow, out_result},
              {1'b1, lit});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] bp_a[5];
        logic [63:0] bp_b[5];
        logic [63:0] held;
        logic        acc, stale;
        int          idx, base;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        held = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {out_valid, out_invalid, out_overflow, out_underflow, out_result}, '0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 67'(in_ready), 67'(1));

        directed("basic",  64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000, {3'b000, 64'h4008_0000_0000_0000});
`ifdef FPU_MULT_RNE_EN
        directed("round",  64'h3FF0_0000_0000_0001, 64'h3FF8_0000_0000_0000, {3'b000, 64'h3FF8_0000_0000_0002});
`else
        directed("round",  64'h3FF0_0000_0000_0001, 64'h3FF8_0000_0000_0000, {3'b000, 64'h3FF8_0000_0000_0001});
`endif
        directed("ovf",    64'h7FE0_0000_0000_0000, 64'h4000_0000_0000_0000, {3'b010, 64'h7FF0_0000_0000_0000});
        directed("unf",    64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000, {3'b001, 64'h0});
        directed("inv",    64'h7FF0_0000_0000_0000, 64'h0,                   {3'b100, 64'h7FF8_0000_0000_0000});
        directed("neginf", 64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000, {3'b000, 64'hFFF0_0000_0000_0000});

        // Back-pressure: out_ready low for six cycles while five pairs stream
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = rand_op();
            bp_b[i] = rand_op();
        end
        idx = 0;
        base = n_out;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 30 && idx < 5; c++) begin
            if (c > 0) #1;
            if (c == 3) held = out_result;
            if (c == 6) begin
                check("bp_accepts", 67'(idx), 67'(3));
                check("bp_in_ready", 67'(in_ready), 67'(0));
                check("bp_hold", 67'(out_result), 67'(held));
                out_ready = 1'b1;
            end
            in_valid = 1'b1; in_a = bp_a[idx]; in_b = bp_b[idx];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 20 && (n_out - base) < 5; k++) @(posedge clk);
        check("bp_count", 67'(n_out - base), 67'(5));

        // Reset with two operations in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 64'h4000_0000_0000_0000; in_b = 64'h4008_0000_0000_0000;
        @(posedge clk); #1;
        in_a = 64'h3FF8_0000_0000_0000; in_b = 64'h3FF8_0000_0000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_valid", 67'(out_valid), 67'(1));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_async", {out_valid, out_invalid, out_overflow, out_underflow, out_result}, '0);
        @(posedge clk); @(posedge clk); #1;
        out_ready = 1'b1;
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("rst_no_stale", 67'(stale), 67'(0));
        directed("post_rst", 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000, {3'b000, 64'h4008_0000_0000_0000});

        // Randomised traffic with random back-pressure
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 99) < 70);
            in_a      = rand_op();
            in_b      = rand_op();
            out_ready = ($urandom_range(0, 99) < 70);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", 67'(exp_q.size()), 67'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
